// File: rtl/pc_sequencer.sv
// Next-PC selection and return-address stack for the core front end.
// Chooses branch, stall, return, call, jump, halt or sequential fetch each cycle and registers it.
module pc_sequencer #(
    parameter int unsigned      WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VEC = '0,
    parameter int unsigned      RAS_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             br_taken,
    input  logic [WIDTH-1:0] br_target,
    input  logic             jmp,
    input  logic [WIDTH-1:0] jmp_target,
    input  logic             call,
    input  logic [WIDTH-1:0] call_target,
    input  logic [WIDTH-1:0] link_addr,
    input  logic             ret,
    input  logic             halt,
    input  logic             resume,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pcnext,
    output logic             fetch_valid,
    output logic             flush,
    output logic             ras_err,
    output logic [1:0]       state
);

    localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_BOOT = 2'b00,
        S_RUN  = 2'b01,
        S_HALT = 2'b10
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   pc_q;
    logic               flush_q, flush_d;
    logic               ras_err_q;
    logic [WIDTH-1:0]   stack_q [RAS_DEPTH];
    logic [PTR_W-1:0]   sp_q;
    logic [CNT_W-1:0]   cnt_q;

    logic               push, pop, err_set;
    logic               ras_empty, ras_full;
    logic [PTR_W-1:0]   top_idx;
    logic [WIDTH-1:0]   pc_inc;

    assign ras_empty = (cnt_q == '0);
    assign ras_full  = (cnt_q == CNT_W'(RAS_DEPTH));
    assign top_idx   = sp_q - PTR_W'(1);
    assign pc_inc    = pc_q + WIDTH'(1);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: halt only wins in RUN when nothing of higher priority is present
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_BOOT: state_d = S_RUN;
            S_RUN: begin
                if (!br_taken && !stall && !ret && !call && !jmp && halt) begin
                    state_d = S_HALT;
                end
            end
            S_HALT: begin
                if (br_taken || resume) begin
                    state_d = S_RUN;
                end
            end
            default: state_d = S_BOOT;
        endcase
    end

    // Output / datapath control: next-PC source and stack operation
    always_comb begin
        pcnext  = pc_q;
        flush_d = 1'b0;
        push    = 1'b0;
        pop     = 1'b0;
        err_set = 1'b0;
        case (state_q)
            S_RUN: begin
                if (br_taken) begin
                    pcnext  = br_target;
                    flush_d = 1'b1;
                end else if (stall) begin
                    pcnext = pc_q;
                end else if (ret) begin
                    if (ras_empty) begin
                        pcnext  = pc_inc;
                        err_set = 1'b1;
                    end else begin
                        pcnext = stack_q[top_idx];
                        pop    = 1'b1;
                    end
                end else if (call) begin
                    pcnext  = call_target;
                    push    = 1'b1;
                    err_set = ras_full;
                end else if (jmp) begin
                    pcnext = jmp_target;
                end else if (halt) begin
                    pcnext = pc_q;
                end else begin
                    pcnext = pc_inc;
                end
            end
            S_HALT: begin
                if (br_taken) begin
                    pcnext  = br_target;
                    flush_d = 1'b1;
                end
            end
            default: pcnext = pc_q;
        endcase
    end

    // PC, flush, error and circular return-address stack
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q      <= RESET_VEC;
            flush_q   <= 1'b0;
            ras_err_q <= 1'b0;
            sp_q      <= '0;
            cnt_q     <= '0;
            for (int i = 0; i < int'(RAS_DEPTH); i++) begin
                stack_q[i] <= '0;
            end
        end else begin
            pc_q    <= pcnext;
            flush_q <= flush_d;
            if (err_set) begin
                ras_err_q <= 1'b1;
            end
            if (push) begin
                stack_q[sp_q] <= link_addr;
                sp_q          <= sp_q + PTR_W'(1);
                if (!ras_full) begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end else if (pop) begin
                sp_q  <= top_idx;
                cnt_q <= cnt_q - CNT_W'(1);
            end
        end
    end

    assign pc          = pc_q;
    assign flush       = flush_q;
    assign ras_err     = ras_err_q;
    assign state       = state_q;
    assign fetch_valid = (state_q == S_RUN) && !flush_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with hand-computed expected PC, state and control values.
module tb_pc_sequencer;

    localparam int unsigned WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             stall;
    logic             br_taken;
    logic [WIDTH-1:0] br_target;
    logic             jmp;
    logic [WIDTH-1:0] jmp_target;
    logic             call;
    logic [WIDTH-1:0] call_target;
    logic [WIDTH-1:0] link_addr;
    logic             ret;
    logic             halt;
    logic             resume;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pcnext;
    logic             fetch_valid;
    logic             flush;
    logic             ras_err;
    logic [1:0]       state;

    int checks;
    int failures;

    pc_sequencer #(
        .WIDTH     (WIDTH),
        .RESET_VEC (8'h00),
        .RAS_DEPTH (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .jmp         (jmp),
        .jmp_target  (jmp_target),
        .call        (call),
        .call_target (call_target),
        .link_addr   (link_addr),
        .ret         (ret),
        .halt        (halt),
        .resume      (resume),
        .pc          (pc),
        .pcnext      (pcnext),
        .fetch_valid (fetch_valid),
        .flush       (flush),
        .ras_err     (ras_err),
        .state       (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_req();
        stall       = 1'b0;
        br_taken    = 1'b0;
        br_target   = '0;
        jmp         = 1'b0;
        jmp_target  = '0;
        call        = 1'b0;
        call_target = '0;
        link_addr   = '0;
        ret         = 1'b0;
        halt        = 1'b0;
        resume      = 1'b0;
    endtask

    task automatic reset_and_boot();
        rst_n = 1'b0;
        #1;
        check_eq("rst_pc", 32'(pc), 32'h00);
        check_eq("rst_state", 32'(state), 32'h0);
        check_eq("rst_ras_err", 32'(ras_err), 32'h0);
        check_eq("rst_flush", 32'(flush), 32'h0);
        check_eq("rst_fv", 32'(fetch_valid), 32'h0);
        tick();
        rst_n = 1'b1;
        check_eq("boot_pcnext", 32'(pcnext), 32'h00);
        tick();
        check_eq("run_pc", 32'(pc), 32'h00);
        check_eq("run_state", 32'(state), 32'h1);
        check_eq("run_fv", 32'(fetch_valid), 32'h1);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        clear_req();
        repeat (2) tick();

        // Reset release: BOOT, then RUN at 00, then sequential
        reset_and_boot();
        tick(); check_eq("seq1", 32'(pc), 32'h01);
        tick(); check_eq("seq2", 32'(pc), 32'h02);
        tick(); check_eq("seq3", 32'(pc), 32'h03);

        // Wrap at FF
        jmp = 1'b1; jmp_target = 8'hFE;
        #1 check_eq("jmp_pcnext", 32'(pcnext), 32'hFE);
        tick(); clear_req();
        check_eq("jmp_pc", 32'(pc), 32'hFE);
        tick(); check_eq("wrap_ff", 32'(pc), 32'hFF);
        tick(); check_eq("wrap_00", 32'(pc), 32'h00);
        check_eq("wrap_err", 32'(ras_err), 32'h0);

        // Nested call / return
        call = 1'b1; call_target = 8'h40; link_addr = 8'h11;
        tick(); check_eq("call1", 32'(pc), 32'h40);
        call_target = 8'h60; link_addr = 8'h41;
        tick(); check_eq("call2", 32'(pc), 32'h60);
        clear_req(); ret = 1'b1;
        #1 check_eq("ret_pcnext", 32'(pcnext), 32'h41);
        tick(); check_eq("ret1", 32'(pc), 32'h41);
        tick(); check_eq("ret2", 32'(pc), 32'h11);
        clear_req();
        check_eq("call_err", 32'(ras_err), 32'h0);

        // Branch beats stall and call
        br_taken = 1'b1; br_target = 8'h80; stall = 1'b1;
        call = 1'b1; call_target = 8'h99; link_addr = 8'h55;
        tick(); clear_req();
        check_eq("br_pc", 32'(pc), 32'h80);
        check_eq("br_flush", 32'(flush), 32'h1);
        check_eq("br_fv", 32'(fetch_valid), 32'h0);
        tick();
        check_eq("br_pc_next", 32'(pc), 32'h81);
        check_eq("br_flush_off", 32'(flush), 32'h0);
        check_eq("br_fv_on", 32'(fetch_valid), 32'h1);
        // Stack must still be empty: ret underflows
        ret = 1'b1;
        tick(); clear_req();
        check_eq("br_nopush_pc", 32'(pc), 32'h82);
        check_eq("br_nopush_err", 32'(ras_err), 32'h1);

        // Stall holds pc and drops decode requests
        stall = 1'b1; jmp = 1'b1; jmp_target = 8'h77;
        tick(); check_eq("stall1", 32'(pc), 32'h82);
        tick(); check_eq("stall2", 32'(pc), 32'h82);
        clear_req();

        // Back-to-back branches
        br_taken = 1'b1; br_target = 8'h90;
        tick(); check_eq("bb1_pc", 32'(pc), 32'h90); check_eq("bb1_flush", 32'(flush), 32'h1);
        br_target = 8'hA0;
        tick(); check_eq("bb2_pc", 32'(pc), 32'hA0); check_eq("bb2_flush", 32'(flush), 32'h1);
        clear_req();
        tick(); check_eq("bb3_flush", 32'(flush), 32'h0);

        // Overflow: 5 calls into a 4-deep stack
        reset_and_boot();
        for (int i = 1; i <= 5; i++) begin
            call = 1'b1; call_target = 8'(8'h10 * i); link_addr = 8'(i);
            tick();
            check_eq($sformatf("ovf_call%0d", i), 32'(pc), 32'(8'h10 * i));
            check_eq($sformatf("ovf_err%0d", i), 32'(ras_err), (i == 5) ? 32'h1 : 32'h0);
        end
        clear_req(); ret = 1'b1;
        for (int i = 5; i >= 2; i--) begin
            tick();
            check_eq($sformatf("ovf_ret%0d", i), 32'(pc), 32'(i));
        end
        tick();
        check_eq("ovf_under_pc", 32'(pc), 32'h03);
        check_eq("ovf_sticky", 32'(ras_err), 32'h1);
        clear_req();
        tick(); check_eq("ovf_sticky2", 32'(ras_err), 32'h1);

        // Halt / resume
        jmp = 1'b1; jmp_target = 8'h20;
        tick(); clear_req();
        check_eq("h_pc", 32'(pc), 32'h20);
        halt = 1'b1;
        tick(); clear_req();
        check_eq("h_state", 32'(state), 32'h2);
        check_eq("h_pc_hold", 32'(pc), 32'h20);
        check_eq("h_fv", 32'(fetch_valid), 32'h0);
        jmp = 1'b1; jmp_target = 8'h77; call = 1'b1; ret = 1'b1;
        tick(); clear_req();
        check_eq("h_ignore_pc", 32'(pc), 32'h20);
        check_eq("h_ignore_state", 32'(state), 32'h2);
        resume = 1'b1;
        tick(); clear_req();
        check_eq("res_state", 32'(state), 32'h1);
        check_eq("res_pc", 32'(pc), 32'h20);
        check_eq("res_fv", 32'(fetch_valid), 32'h1);
        tick(); check_eq("res_seq", 32'(pc), 32'h21);

        // Halt then wrong-path branch
        halt = 1'b1;
        tick(); clear_req();
        check_eq("h2_state", 32'(state), 32'h2);
        br_taken = 1'b1; br_target = 8'h30;
        tick(); clear_req();
        check_eq("hbr_pc", 32'(pc), 32'h30);
        check_eq("hbr_state", 32'(state), 32'h1);
        check_eq("hbr_flush", 32'(flush), 32'h1);
        halt = 1'b1;
        tick(); clear_req();
        check_eq("h3_state", 32'(state), 32'h2);
        check_eq("h3_pc", 32'(pc), 32'h30);

        // Asynchronous reset while halted
        rst_n = 1'b0;
        #1;
        check_eq("hrst_pc", 32'(pc), 32'h00);
        check_eq("hrst_state", 32'(state), 32'h0);
        check_eq("hrst_err", 32'(ras_err), 32'h0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
